regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file for the datapath.
- Provides NUM_RD combinational read ports and two prioritised write ports.
- Features: optional write-to-read bypass, hardwired zero register, per-register reset image and a sequenced soft-clear engine.
- Sits between decode (read addresses) and writeback (write ports).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of read ports (1..4)
BYPASS, 1, 1 = a read of an address written this cycle returns the write data
INIT_IDX, 29, index loaded with INIT_VAL on reset/clear (stack pointer)
INIT_VAL, 252, reset value of entry INIT_IDX; all other entries reset to 0

Ports:
clk  in  1  clock, all state on rising edge
nrst  in  1  asynchronous active-low reset
rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W]
wr_en0  in  1  write port 0 enable
wr_addr0  in  ADDR_W  write port 0 address
wr_data0  in  DATA_W  write port 0 data
wr_en1  in  1  write port 1 enable (higher priority)
wr_addr1  in  ADDR_W  write port 1 address
wr_data1  in  DATA_W  write port 1 data
clr_req  in  1  start soft clear (level sampled in IDLE)
busy  out  1  clear in progress
clr_done  out  1  one-cycle pulse when clear completes
wr_zero_err  out  1  registered pulse: enabled write to address 0 was attempted
wr_drop  out  1  registered pulse: enabled write was dropped because busy

Behaviour:
- Reset (nrst=0, asynchronous):
  - every entry := 0, except entry INIT_IDX := INIT_VAL.
  - FSM := IDLE; busy, clr_done, wr_zero_err, wr_drop := 0; clear counter := 0.
- Reads are combinational, with no clock latency.
  - Read of address 0 always returns 0.
  - Otherwise the read returns the array entry, subject to bypass.
- Bypass (BYPASS=1, busy=0):
  - If wr_en1 is high, wr_addr1 matches the read address and the address is nonzero, the read returns wr_data1.
  - Otherwise, if the same holds for port 0, the read returns wr_data0.
  - Otherwise the read returns the array.
  - BYPASS=0: the read returns the stored value; new data is visible the cycle after the write.
- Writes commit on the rising edge.
  - Write to address 0 is discarded and sets wr_zero_err=1 for the next cycle.
  - If both ports write the same address, port 1 wins.
  - Different addresses: both commit.
- FSM states: IDLE, CLEAR, DONE.
  - IDLE: clr_req=1 -> CLEAR; counter := 0; busy := 1.
  - CLEAR: each cycle, entry[counter] := reset image value and counter++.
    - After entry DEPTH-1 is written -> DONE.
    - Takes exactly DEPTH cycles in CLEAR.
  - DONE: clr_done=1 and busy=0 for one cycle, then -> IDLE. A clr_req in DONE is ignored.
- While busy=1:
  - All writes are dropped, with no array update; wr_drop=1 next cycle if either wr_en is high.
  - Bypass is disabled.
  - Reads return current array contents (partially cleared).
  - clr_req is ignored.
- Both error pulses follow the enables each cycle; they are not sticky.
- nrst asserted mid-clear: array goes to the reset image immediately, FSM -> IDLE, no clr_done.
- Counter is ADDR_W bits; wrap from DEPTH-1 is the exit condition, not an overflow.

Test Plan:
- Reset with default parameters -> read ports 0 and 1 at addresses 29 and 5 return 252 and 0. All flags are 0.
- Write 0xDEADBEEF to address 7 on port 0; same cycle read address 7.
  - BYPASS=1: 0xDEADBEEF in the same cycle.
  - BYPASS=0: old value 0, then 0xDEADBEEF the next cycle.
- Both ports write address 3 (port 0 0x11, port 1 0x22) -> address 3 reads 0x22. A port 0 write of 0x55 to address 0 -> address 0 reads 0 and wr_zero_err pulses once.
- Preload addresses 1..31 with index*4, then pulse clr_req:
  - busy is high for 32 cycles, then clr_done is high for 1 cycle.
  - Afterwards all entries are 0 except address 29 = 252.
  - A write to address 4 at clear cycle 10 is dropped (wr_drop pulses) and address 4 reads 0 afterwards.
- Drop nrst at clear cycle 12 -> busy falls asynchronously, clr_done never pulses, array equals the reset image, and a new clr_req is accepted after release.
- NUM_RD=4, ADDR_W=3 build: 4 ports read addresses 0, 1, 2, 7 after writes of 0xA, 0xB, 0xC -> 0, 0xA, 0xB, 0xC. Clear takes 8 cycles.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with combinational read
// ports, two prioritised write ports, optional write-to-read bypass, a
// hardwired zero register and a sequenced soft-clear engine that restores
// the reset image one entry per cycle.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int INIT_IDX = 29,
  parameter int INIT_VAL = 252
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic                       wr_en0,
  input  logic [ADDR_W-1:0]          wr_addr0,
  input  logic [DATA_W-1:0]          wr_data0,
  input  logic                       wr_en1,
  input  logic [ADDR_W-1:0]          wr_addr1,
  input  logic [DATA_W-1:0]          wr_data1,
  input  logic                       clr_req,
  output logic                       busy,
  output logic                       clr_done,
  output logic                       wr_zero_err,
  output logic                       wr_drop
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Reset image: every entry is zero except the stack pointer entry.
  function automatic logic [DATA_W-1:0] reset_val(input logic [ADDR_W-1:0] idx);
    logic [DATA_W-1:0] v;
    if (idx == ADDR_W'(INIT_IDX)) begin
      v = DATA_W'(INIT_VAL);
    end else begin
      v = {DATA_W{1'b0}};
    end
    return v;
  endfunction

  logic [DATA_W-1:0] mem_r [DEPTH];
  state_t            state_r;
  logic [ADDR_W-1:0] clr_cnt_r;
  logic              busy_r;
  logic              clr_done_r;
  logic              wr_zero_err_r;
  logic              wr_drop_r;
  logic              wr0_ok_s;
  logic              wr1_ok_s;
  logic [ADDR_W-1:0] ra_s;

  assign busy        = busy_r;
  assign clr_done    = clr_done_r;
  assign wr_zero_err = wr_zero_err_r;
  assign wr_drop     = wr_drop_r;

  // Qualify write ports: no address 0, nothing while clearing, port 1 wins on collision.
  always_comb begin
    wr1_ok_s = 1'b0;
    wr0_ok_s = 1'b0;
    if (!busy_r) begin
      wr1_ok_s = wr_en1 && (wr_addr1 != {ADDR_W{1'b0}});
      wr0_ok_s = wr_en0 && (wr_addr0 != {ADDR_W{1'b0}}) &&
                 !(wr1_ok_s && (wr_addr1 == wr_addr0));
    end else begin
      wr1_ok_s = 1'b0;
      wr0_ok_s = 1'b0;
    end
  end

  // Storage array: reset image on nrst, one entry per cycle while clearing, else writes.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= reset_val(ADDR_W'(i));
      end
    end else if (state_r == ST_CLEAR) begin
      mem_r[clr_cnt_r] <= reset_val(clr_cnt_r);
    end else begin
      if (wr0_ok_s) begin
        mem_r[wr_addr0] <= wr_data0;
      end
      if (wr1_ok_s) begin
        mem_r[wr_addr1] <= wr_data1;
      end
    end
  end

  // Soft-clear sequencer with registered busy / clr_done.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r    <= ST_IDLE;
      clr_cnt_r  <= {ADDR_W{1'b0}};
      busy_r     <= 1'b0;
      clr_done_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          clr_done_r <= 1'b0;
          if (clr_req) begin
            state_r   <= ST_CLEAR;
            clr_cnt_r <= {ADDR_W{1'b0}};
            busy_r    <= 1'b1;
          end
        end
        ST_CLEAR: begin
          // The counter wrapping from DEPTH-1 back to 0 marks the last entry.
          clr_cnt_r <= clr_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          if (clr_cnt_r == {ADDR_W{1'b1}}) begin
            state_r    <= ST_DONE;
            busy_r     <= 1'b0;
            clr_done_r <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r    <= ST_IDLE;
          busy_r     <= 1'b0;
          clr_done_r <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          clr_cnt_r  <= {ADDR_W{1'b0}};
          busy_r     <= 1'b0;
          clr_done_r <= 1'b0;
        end
      endcase
    end
  end

  // Error pulses track the write enables of the previous cycle; not sticky.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_zero_err_r <= 1'b0;
      wr_drop_r     <= 1'b0;
    end else begin
      wr_zero_err_r <= (wr_en0 && (wr_addr0 == {ADDR_W{1'b0}})) ||
                       (wr_en1 && (wr_addr1 == {ADDR_W{1'b0}}));
      wr_drop_r     <= busy_r && (wr_en0 || wr_en1);
    end
  end

  // Combinational read ports with zero register and optional same-cycle bypass.
  always_comb begin
    rd_data = {(NUM_RD*DATA_W){1'b0}};
    ra_s    = {ADDR_W{1'b0}};
    for (int k = 0; k < NUM_RD; k++) begin
      ra_s = rd_addr[k*ADDR_W +: ADDR_W];
      if (ra_s == {ADDR_W{1'b0}}) begin
        rd_data[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end else if ((BYPASS != 0) && !busy_r && wr_en1 && (wr_addr1 == ra_s)) begin
        rd_data[k*DATA_W +: DATA_W] = wr_data1;
      end else if ((BYPASS != 0) && !busy_r && wr_en0 && (wr_addr0 == ra_s)) begin
        rd_data[k*DATA_W +: DATA_W] = wr_data0;
      end else begin
        rd_data[k*DATA_W +: DATA_W] = mem_r[ra_s];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp. Three builds
// share clock and reset: default (bypass on), bypass off, and a 4-port
// 8-entry build.
module tb_regfile_mp;

  logic        clk;
  logic        nrst;

  // Default and no-bypass builds share all stimulus.
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [63:0] nb_rd_data;
  logic        wr_en0, wr_en1, clr_req;
  logic [4:0]  wr_addr0, wr_addr1;
  logic [31:0] wr_data0, wr_data1;
  logic        busy, clr_done, wr_zero_err, wr_drop;
  logic        nb_busy, nb_clr_done, nb_wr_zero_err, nb_wr_drop;

  // Small build: NUM_RD=4, ADDR_W=3, stack entry 6 = 0x3C.
  logic [11:0]  s_rd_addr;
  logic [127:0] s_rd_data;
  logic         s_wr_en0, s_wr_en1, s_clr_req;
  logic [2:0]   s_wr_addr0, s_wr_addr1;
  logic [31:0]  s_wr_data0, s_wr_data1;
  logic         s_busy, s_clr_done, s_wr_zero_err, s_wr_drop;

  int n_checks;
  int n_fail;
  int c;

  regfile_mp dut (
    .clk(clk), .nrst(nrst), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .clr_req(clr_req), .busy(busy), .clr_done(clr_done),
    .wr_zero_err(wr_zero_err), .wr_drop(wr_drop)
  );

  regfile_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .nrst(nrst), .rd_addr(rd_addr), .rd_data(nb_rd_data),
    .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .clr_req(clr_req), .busy(nb_busy), .clr_done(nb_clr_done),
    .wr_zero_err(nb_wr_zero_err), .wr_drop(nb_wr_drop)
  );

  regfile_mp #(.NUM_RD(4), .ADDR_W(3), .INIT_IDX(6), .INIT_VAL(60)) dut_s (
    .clk(clk), .nrst(nrst), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
    .wr_en0(s_wr_en0), .wr_addr0(s_wr_addr0), .wr_data0(s_wr_data0),
    .wr_en1(s_wr_en1), .wr_addr1(s_wr_addr1), .wr_data1(s_wr_data1),
    .clr_req(s_clr_req), .busy(s_busy), .clr_done(s_clr_done),
    .wr_zero_err(s_wr_zero_err), .wr_drop(s_wr_drop)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    nrst = 1'b0;
    rd_addr = 10'd0; wr_en0 = 1'b0; wr_en1 = 1'b0; clr_req = 1'b0;
    wr_addr0 = 5'd0; wr_addr1 = 5'd0; wr_data0 = 32'd0; wr_data1 = 32'd0;
    s_rd_addr = 12'd0; s_wr_en0 = 1'b0; s_wr_en1 = 1'b0; s_clr_req = 1'b0;
    s_wr_addr0 = 3'd0; s_wr_addr1 = 3'd0; s_wr_data0 = 32'd0; s_wr_data1 = 32'd0;
    repeat (3) tick();
    nrst = 1'b1;
    tick();

    // Reset image and flags.
    rd_addr = {5'd5, 5'd29};
    #1;
    check_val("rst_rd0_a29", rd_data[31:0], 32'd252);
    check_val("rst_rd1_a5", rd_data[63:32], 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_clr_done", {31'd0, clr_done}, 32'd0);
    check_val("rst_zero_err", {31'd0, wr_zero_err}, 32'd0);
    check_val("rst_drop", {31'd0, wr_drop}, 32'd0);

    // Bypass versus stored read.
    wr_en0 = 1'b1; wr_addr0 = 5'd7; wr_data0 = 32'hDEADBEEF; rd_addr = {5'd0, 5'd7};
    #1;
    check_val("byp_same_cycle", rd_data[31:0], 32'hDEADBEEF);
    check_val("nobyp_same_cycle", nb_rd_data[31:0], 32'd0);
    tick();
    wr_en0 = 1'b0;
    #1;
    check_val("nobyp_next_cycle", nb_rd_data[31:0], 32'hDEADBEEF);
    check_val("byp_after_commit", rd_data[31:0], 32'hDEADBEEF);

    // Same-address collision: port 1 wins, also in the bypass path.
    wr_en0 = 1'b1; wr_addr0 = 5'd3; wr_data0 = 32'h11;
    wr_en1 = 1'b1; wr_addr1 = 5'd3; wr_data1 = 32'h22;
    rd_addr = {5'd0, 5'd3};
    #1;
    check_val("byp_prio_p1", rd_data[31:0], 32'h22);
    tick();
    // Different addresses both commit.
    wr_addr0 = 5'd9; wr_data0 = 32'h99; wr_addr1 = 5'd10; wr_data1 = 32'hAA;
    tick();
    wr_en0 = 1'b0; wr_en1 = 1'b0;
    rd_addr = {5'd9, 5'd3};
    #1;
    check_val("collide_a3", rd_data[31:0], 32'h22);
    check_val("collide_a3_nb", nb_rd_data[31:0], 32'h22);
    check_val("dual_a9", rd_data[63:32], 32'h99);
    rd_addr = {5'd0, 5'd10};
    #1;
    check_val("dual_a10", rd_data[31:0], 32'hAA);

    // Write to address 0.
    wr_en0 = 1'b1; wr_addr0 = 5'd0; wr_data0 = 32'h55; rd_addr = {5'd0, 5'd0};
    #1;
    check_val("zero_byp", rd_data[31:0], 32'd0);
    tick();
    wr_en0 = 1'b0;
    check_val("zero_err_pulse", {31'd0, wr_zero_err}, 32'd1);
    check_val("zero_rd", rd_data[31:0], 32'd0);
    tick();
    check_val("zero_err_clear", {31'd0, wr_zero_err}, 32'd0);

    // Preload 1..31 with index*4.
    for (int i = 1; i < 32; i++) begin
      wr_en0 = 1'b1; wr_addr0 = 5'(i); wr_data0 = 32'(i * 4);
      tick();
    end
    wr_en0 = 1'b0;
    rd_addr = {5'd20, 5'd31};
    #1;
    check_val("pre_a31", rd_data[31:0], 32'd124);
    check_val("pre_a20", rd_data[63:32], 32'd80);

    // Soft clear with a dropped write at clear cycle 10.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    c = 0;
    while (busy && c < 100) begin
      if (c == 10) begin
        wr_en0 = 1'b1; wr_addr0 = 5'd4; wr_data0 = 32'h1234; rd_addr = {5'd20, 5'd4};
        #1;
        check_val("busy_no_byp_a4", rd_data[31:0], 32'd0);
        check_val("busy_partial_a20", rd_data[63:32], 32'd80);
      end else begin
        wr_en0 = 1'b0;
      end
      if (c == 11) check_val("drop_pulse", {31'd0, wr_drop}, 32'd1);
      if (c == 12) check_val("drop_clear", {31'd0, wr_drop}, 32'd0);
      tick();
      c++;
    end
    wr_en0 = 1'b0;
    check_val("clear_cycles", c, 32'd32);
    check_val("clr_done_pulse", {31'd0, clr_done}, 32'd1);
    check_val("done_busy_low", {31'd0, busy}, 32'd0);
    tick();
    check_val("clr_done_once", {31'd0, clr_done}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      rd_addr = {5'd0, 5'(i)};
      #1;
      check_val($sformatf("post_clr_a%0d", i), rd_data[31:0], (i == 29) ? 32'd252 : 32'd0);
    end

    // Reset in the middle of a clear.
    wr_en0 = 1'b1; wr_addr0 = 5'd20; wr_data0 = 32'h77;
    wr_en1 = 1'b1; wr_addr1 = 5'd29; wr_data1 = 32'h5;
    tick();
    wr_en0 = 1'b0; wr_en1 = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (12) tick();
    check_val("mid_busy_high", {31'd0, busy}, 32'd1);
    nrst = 1'b0;
    #1;
    check_val("mid_busy_async", {31'd0, busy}, 32'd0);
    rd_addr = {5'd29, 5'd20};
    #1;
    check_val("mid_rst_a20", rd_data[31:0], 32'd0);
    check_val("mid_rst_a29", rd_data[63:32], 32'd252);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("mid_no_done", {31'd0, clr_done}, 32'd0);
    end
    nrst = 1'b1;
    tick();
    check_val("mid_after_rel_done", {31'd0, clr_done}, 32'd0);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check_val("reclear_busy", {31'd0, busy}, 32'd1);
    c = 0;
    while (busy && c < 100) begin
      tick();
      c++;
    end
    check_val("reclear_cycles", c, 32'd32);
    check_val("reclear_done", {31'd0, clr_done}, 32'd1);
    tick();

    // Small 4-port build.
    s_wr_en0 = 1'b1; s_wr_addr0 = 3'd1; s_wr_data0 = 32'hA;
    s_wr_en1 = 1'b1; s_wr_addr1 = 3'd2; s_wr_data1 = 32'hB;
    tick();
    s_wr_addr0 = 3'd7; s_wr_data0 = 32'hC; s_wr_en1 = 1'b0;
    tick();
    s_wr_en0 = 1'b0;
    s_rd_addr = {3'd7, 3'd2, 3'd1, 3'd0};
    #1;
    check_val("s_rd0_a0", s_rd_data[31:0], 32'd0);
    check_val("s_rd1_a1", s_rd_data[63:32], 32'hA);
    check_val("s_rd2_a2", s_rd_data[95:64], 32'hB);
    check_val("s_rd3_a7", s_rd_data[127:96], 32'hC);
    s_clr_req = 1'b1;
    tick();
    s_clr_req = 1'b0;
    c = 0;
    while (s_busy && c < 100) begin
      tick();
      c++;
    end
    check_val("s_clear_cycles", c, 32'd8);
    check_val("s_clr_done", {31'd0, s_clr_done}, 32'd1);
    s_rd_addr = {3'd6, 3'd7, 3'd1, 3'd2};
    #1;
    check_val("s_post_a2", s_rd_data[31:0], 32'd0);
    check_val("s_post_a1", s_rd_data[63:32], 32'd0);
    check_val("s_post_a7", s_rd_data[95:64], 32'd0);
    check_val("s_post_a6", s_rd_data[127:96], 32'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
